rr_mux_arbiter_4: RTL and testbench

- Shares one output channel between four requesters with valid/ready handshake.
- A round-robin arbiter picks the winning requester and drives the select of an internal 4:1 data mux.
- The winning beat is captured into a single-entry output register.
- Sits in front of any single-consumer resource, e.g. a shared bus, FIFO or ALU port.

---
 rtl/rr_mux_arbiter_4.sv | 107 ++++++++++
 tb/tb_rr_mux_arbiter_4.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter_4.sv
// rr_mux_arbiter_4: four-way round-robin arbiter feeding a registered 4:1 mux.
// Optional PACKET_LOCK_EN holds the grant on one requester until in_last.
module rr_mux_arbiter_4 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   in_valid,
    output logic [3:0]   in_ready,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
`ifdef PACKET_LOCK_EN
    input  logic [3:0]   in_last,
    output logic         out_last,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_src
);

    logic [1:0]   last_grant;
    logic [1:0]   rr_g;
    logic         rr_found;
    logic [1:0]   g;
    logic         found;
    logic         can_load;
    logic         xfer;
    logic [W-1:0] mux_data;

`ifdef PACKET_LOCK_EN
    logic         locked;
`endif

    assign can_load = !out_valid || out_ready;

    // Round-robin scan starting one past the last winner.
    always_comb begin
        rr_found = 1'b0;
        rr_g     = last_grant;
        for (int k = 1; k < 5; k++) begin
            if (!rr_found && in_valid[last_grant + 2'(k)]) begin
                rr_found = 1'b1;
                rr_g     = last_grant + 2'(k);
            end
        end
    end

    // Final grant: a locked packet bypasses the rotation.
    always_comb begin
        g     = rr_g;
        found = rr_found;
`ifdef PACKET_LOCK_EN
        if (locked) begin
            g     = last_grant;
            found = in_valid[last_grant];
        end
`endif
    end

    assign xfer     = rst_n && can_load && found;
    assign in_ready = xfer ? (4'b0001 << g) : 4'b0000;

    // Data mux steered by the grant; unselected inputs never propagate.
    always_comb begin
        mux_data = '0;
        unique case (g)
            2'd0: mux_data = d0;
            2'd1: mux_data = d1;
            2'd2: mux_data = d2;
            2'd3: mux_data = d3;
        endcase
    end

    // Output register and grant pointer; load wins over drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= 2'd0;
            last_grant <= 2'd3;
        end else if (xfer) begin
            out_valid  <= 1'b1;
            out_data   <= mux_data;
            out_src    <= g;
            last_grant <= g;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

`ifdef PACKET_LOCK_EN
    // Packet lock state and the registered last flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked   <= 1'b0;
            out_last <= 1'b0;
        end else if (xfer) begin
            locked   <= !in_last[g];
            out_last <= in_last[g];
        end
    end
`endif

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// tb_rr_mux_arbiter_4: directed vectors for rr_mux_arbiter_4.
// Checks reset, rotation, stall, idle skip, async reset and packet lock.
module tb_rr_mux_arbiter_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic [3:0] d0, d1, d2, d3;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_src;
`ifdef PACKET_LOCK_EN
    logic [3:0] in_last;
    logic       out_last;
`endif

    int n_chk;
    int n_err;

    rr_mux_arbiter_4 #(.W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
`ifdef PACKET_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge, then expect a fresh beat from requester src.
    task automatic step(input string tag, input logic [1:0] src,
                        input logic [3:0] data);
        @(posedge clk);
        #1;
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".src"}, 32'(out_src), 32'(src));
        check({tag, ".data"}, 32'(out_data), 32'(data));
    endtask

    logic [3:0] exp_d [4];

    initial begin
        n_chk = 0;
        n_err = 0;
        exp_d[0] = 4'ha;
        exp_d[1] = 4'hb;
        exp_d[2] = 4'hc;
        exp_d[3] = 4'hd;
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        d0 = 4'h0; d1 = 4'h0; d2 = 4'h0; d3 = 4'h0;
`ifdef PACKET_LOCK_EN
        in_last = 4'b1111;
`endif
        #12;
        check("rst.in_ready", 32'(in_ready), 32'h0);
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.data", 32'(out_data), 32'h0);
        check("rst.src", 32'(out_src), 32'd0);
`ifdef PACKET_LOCK_EN
        check("rst.last", 32'(out_last), 32'd0);
`endif

        // Single requester 2
        in_valid = 4'b0100;
        d2 = 4'hc;
        rst_n = 1'b1;
        #1;
        check("single.in_ready", 32'(in_ready), 32'b0100);
        step("single", 2'd2, 4'hc);
        in_valid = 4'b0000;
        @(posedge clk);
        #1;
        check("single.drain", 32'(out_valid), 32'd0);

        // Fresh reset so rotation starts at 0
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        d0 = 4'ha; d1 = 4'hb; d2 = 4'hc; d3 = 4'hd;
        in_valid = 4'b1111;
        #1;
        check("rr.first_ready", 32'(in_ready), 32'b0001);
        for (int i = 0; i < 8; i++)
            step("rr", 2'(i), exp_d[i % 4]);

        // Load 0 then 1, then stall on requester 1's beat
        step("pre_stall0", 2'd0, 4'ha);
        step("pre_stall1", 2'd1, 4'hb);
        out_ready = 1'b0;
        #1;
        check("stall.in_ready0", 32'(in_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("stall.in_ready", 32'(in_ready), 32'h0);
            check("stall.src", 32'(out_src), 32'd1);
            check("stall.data", 32'(out_data), 32'hb);
            check("stall.valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("stall.resume_ready", 32'(in_ready), 32'b0100);
        step("stall.resume", 2'd2, 4'hc);

        // Skip idle requesters
        in_valid = 4'b0001;
        step("skip.set0", 2'd0, 4'ha);
        in_valid = 4'b1001;
        step("skip.g3", 2'd3, 4'hd);
        step("skip.g0", 2'd0, 4'ha);
        in_valid = 4'b0000;
        @(posedge clk);
        #1;
        check("idle.drain", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("idle.valid", 32'(out_valid), 32'd0);
        check("idle.src_hold", 32'(out_src), 32'd0);
        check("idle.data_hold", 32'(out_data), 32'ha);
        in_valid = 4'b1111;
        #1;
        check("idle.ptr", 32'(in_ready), 32'b0010);
        step("idle.next", 2'd1, 4'hb);

        // Async reset while stalled
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("areset.valid", 32'(out_valid), 32'd0);
        check("areset.data", 32'(out_data), 32'h0);
        check("areset.in_ready", 32'(in_ready), 32'h0);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check("areset.first_ready", 32'(in_ready), 32'b0001);
        step("areset.g0", 2'd0, 4'ha);

`ifdef PACKET_LOCK_EN
        // Requester 1 holds the grant for a 3-beat packet
        in_last = 4'b0000;
        step("lock.b0", 2'd1, 4'hb);
        check("lock.b0.last", 32'(out_last), 32'd0);
        #1;
        check("lock.ready", 32'(in_ready), 32'b0010);
        step("lock.b1", 2'd1, 4'hb);
        check("lock.b1.last", 32'(out_last), 32'd0);
        in_last = 4'b0010;
        step("lock.b2", 2'd1, 4'hb);
        check("lock.b2.last", 32'(out_last), 32'd1);
        step("lock.after", 2'd2, 4'hc);
        check("lock.after.last", 32'(out_last), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
